// File: rtl/booth_pkg.sv
// Shared types and sizing helpers for the sequential Booth multiplier.
package booth_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  typedef enum logic [2:0] {ZERO, POS1, NEG1, POS2, NEG2} booth_digit_e;

  function automatic int booth_iters(input int width, input bit radix4);
    return radix4 ? (width / 2 + 1) : (width + 1);
  endfunction

  // Product register: accumulator (WIDTH+4) | consumed multiplier bits | b[-1]
  function automatic int booth_pw(input int width, input bit radix4);
    return (width + 4) + (radix4 ? (width + 2) : (width + 1)) + 1;
  endfunction

endpackage

// File: rtl/booth_mult_seq_if.sv
// Operand/result bundle between a requester and booth_mult_seq.
interface booth_mult_seq_if #(
  parameter int WIDTH = 64
);
  logic                 op_start;
  logic                 op_clear;
  logic                 is_signed;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic [2*WIDTH-1:0]   result;
  logic                 busy;
  logic                 done;

  modport master (
    output op_start, op_clear, is_signed, multiplicand, multiplier,
    input  result, busy, done
  );

  modport slave (
    input  op_start, op_clear, is_signed, multiplicand, multiplier,
    output result, busy, done
  );
endinterface

// File: rtl/booth_step.sv
// One combinational Booth iteration: recode, add/subtract via a prefix
// carry-lookahead adder, then arithmetic shift of the product register.
module booth_step
  import booth_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int RADIX4 = 0
) (
  input  logic [WIDTH+1:0]                            mcand,
  input  logic [booth_pw(WIDTH, RADIX4 != 0)-1:0]     p_in,
  output logic [booth_pw(WIDTH, RADIX4 != 0)-1:0]     p_out
);

  localparam int EW = WIDTH + 2;
  localparam int HW = WIDTH + 4;
  localparam int LW = (RADIX4 != 0) ? (WIDTH + 2) : (WIDTH + 1);
  localparam int PW = HW + LW + 1;
  localparam int SH = (RADIX4 != 0) ? 2 : 1;

  booth_digit_e          digit;
  logic signed [HW-1:0]  a_ext;
  logic signed [HW-1:0]  a_dbl;
  logic        [HW-1:0]  hi;
  logic        [HW-1:0]  addend;
  logic                  cin;
  logic        [HW-1:0]  g, p, gg, pp, gn, pn;
  logic        [HW-1:0]  sum;
  logic        [PW-1:0]  p_next;

  assign a_ext = {{(HW-EW){mcand[EW-1]}}, mcand};
  assign a_dbl = a_ext <<< 1;
  assign hi    = p_in[PW-1 -: HW];

  always_comb begin
    digit = ZERO;
    if (RADIX4 != 0) begin
      case (p_in[2:0])
        3'b001, 3'b010: digit = POS1;
        3'b011:         digit = POS2;
        3'b100:         digit = NEG2;
        3'b101, 3'b110: digit = NEG1;
        default:        digit = ZERO;
      endcase
    end else begin
      case (p_in[1:0])
        2'b01:   digit = POS1;
        2'b10:   digit = NEG1;
        default: digit = ZERO;
      endcase
    end
  end

  // Negative digits add the one's complement with carry-in set
  always_comb begin
    addend = '0;
    cin    = 1'b0;
    case (digit)
      POS1: begin addend = a_ext;  cin = 1'b0; end
      NEG1: begin addend = ~a_ext; cin = 1'b1; end
      POS2: begin addend = a_dbl;  cin = 1'b0; end
      NEG2: begin addend = ~a_dbl; cin = 1'b1; end
      default: begin addend = '0;  cin = 1'b0; end
    endcase
  end

  // Kogge-Stone prefix; carry-in folded into bit 0 generate
  always_comb begin
    g    = hi & addend;
    p    = hi ^ addend;
    g[0] = g[0] | (p[0] & cin);
    gg   = g;
    pp   = p;
    gn   = g;
    pn   = p;
    for (int d = 1; d < HW; d = d * 2) begin
      gn = gg;
      pn = pp;
      for (int i = d; i < HW; i++) begin
        gn[i] = gg[i] | (pp[i] & gg[i-d]);
        pn[i] = pp[i] & pp[i-d];
      end
      gg = gn;
      pp = pn;
    end
    sum = p ^ {gg[HW-2:0], cin};
  end

  assign p_next = {sum, p_in[LW:0]};
  assign p_out  = $signed(p_next) >>> SH;

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential Booth multiplier: FSM, iteration counter and operand/product
// registers around a single combinational booth_step.
module booth_mult_seq
  import booth_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int RADIX4 = 0
) (
  input  logic              clk,
  input  logic              reset,
  booth_mult_seq_if.slave   bus
);

  localparam bit R4  = (RADIX4 != 0);
  localparam int NIT = booth_iters(WIDTH, R4);
  localparam int CW  = $clog2(NIT + 1);
  localparam int PW  = booth_pw(WIDTH, R4);
  localparam int EW  = WIDTH + 2;
  localparam int HW  = WIDTH + 4;
  localparam int LW  = R4 ? (WIDTH + 2) : (WIDTH + 1);

  state_e              state, state_nxt;
  logic [CW-1:0]       cnt;
  logic [EW-1:0]       mcand_r;
  logic [PW-1:0]       prod_r;
  logic [PW-1:0]       prod_step;
  logic [2*WIDTH-1:0]  result_r;
  logic [EW-1:0]       mcand_ext;
  logic [LW-1:0]       mplier_ext;
  logic                load, iterate, finish, clear;

  assign mcand_ext  = {{2{bus.is_signed & bus.multiplicand[WIDTH-1]}}, bus.multiplicand};
  assign mplier_ext = {{(LW-WIDTH){bus.is_signed & bus.multiplier[WIDTH-1]}}, bus.multiplier};

  booth_step #(
    .WIDTH  (WIDTH),
    .RADIX4 (RADIX4)
  ) u_step (
    .mcand (mcand_r),
    .p_in  (prod_r),
    .p_out (prod_step)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    iterate   = 1'b0;
    finish    = 1'b0;
    clear     = 1'b0;
    if (bus.op_clear) begin
      state_nxt = IDLE;
      clear     = 1'b1;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.op_start) begin
            state_nxt = CALC;
            load      = 1'b1;
          end
        end
        CALC: begin
          iterate = 1'b1;
          if (cnt == CW'(1)) begin
            state_nxt = DONE;
            finish    = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // The product sits one bit above b[-1] once all multiplier bits are consumed
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt      <= '0;
      mcand_r  <= '0;
      prod_r   <= '0;
      result_r <= '0;
    end else if (load) begin
      cnt      <= CW'(NIT);
      mcand_r  <= mcand_ext;
      prod_r   <= {{HW{1'b0}}, mplier_ext, 1'b0};
      result_r <= '0;
    end else if (iterate) begin
      cnt    <= cnt - CW'(1);
      prod_r <= prod_step;
      if (finish) result_r <= prod_step[2*WIDTH:1];
    end
  end

  assign bus.result = result_r;
  assign bus.busy   = (state == CALC);
  assign bus.done   = (state == DONE);

endmodule

// File: doc/booth_mult_seq.md
BOOTH_MULT_SEQ -- requirements
Module: booth_mult_seq

Interface
REQ-001 Parameter WIDTH, default 64, operand width in bits; SHALL be even and >= 4.
REQ-002 Parameter RADIX4, default 0, selects the recoding: 0 = radix-2 Booth, 1 = radix-4 (modified) Booth.
REQ-003 clk  in  1  single clock; all state SHALL change on its rising edge only.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 op_start  in  1  request: load the operands and begin a multiply.
REQ-006 op_clear  in  1  abort: cancel any operation and clear the result.
REQ-007 is_signed  in  1  operand mode: 1 = two's complement, 0 = unsigned; sampled with op_start.
REQ-008 multiplicand  in  WIDTH  operand A; sampled with op_start.
REQ-009 multiplier  in  WIDTH  operand B; sampled with op_start.
REQ-010 result  out  2*WIDTH  product A*B, registered.
REQ-011 busy  out  1  high while iterating.
REQ-012 done  out  1  high while result holds a completed product.

Function
REQ-013 Three-state FSM: IDLE, CALC, DONE.
REQ-014 op_start is accepted only in IDLE or DONE; in CALC it SHALL be ignored.
REQ-015 Acceptance in cycle 0 SHALL have these effects in cycle 1: operands and mode captured, iteration counter loaded, result cleared to 0, done=0, busy=1, state=CALC.
REQ-016 Operands SHALL be extended internally to WIDTH+2 bits: sign-extended when is_signed=1, zero-extended when 0.
REQ-017 Accumulator width SHALL be sufficient that no iteration overflows; the final 2*WIDTH bits SHALL equal the exact product in the selected mode.
REQ-018 Radix-2 iteration: inspect multiplier bit pair {b0,b-1}; 01 adds A, 10 subtracts A, 00/11 add nothing; then arithmetic shift right by 1.
REQ-019 Radix-4 iteration: inspect triplet {b1,b0,b-1}; select from the set 0, +A, -A, +2A, -2A; then arithmetic shift right by 2.
REQ-020 Subtraction SHALL be performed as addition of the inverted operand with carry-in 1.
REQ-021 Iteration count N SHALL be WIDTH+1 for radix-2 and WIDTH/2+1 for radix-4, with one iteration per CALC cycle.
REQ-022 The final iteration SHALL cause a transition to DONE, with result loaded, done=1 and busy=0 in the following cycle. The result is therefore valid N cycles after the first busy cycle.
REQ-023 DONE SHALL hold result and done until an op_start is accepted or op_clear is applied.
REQ-024 op_clear=1 in any state SHALL cause the next state to be IDLE, with result=0, busy=0 and done=0.
REQ-025 op_clear SHALL take priority over op_start in the same cycle.
REQ-026 op_start in DONE SHALL start a new operation directly (DONE->CALC) with no IDLE cycle.
REQ-027 A zero operand SHALL still take the full N cycles; there is no early termination.
REQ-028 Operand input changes after acceptance SHALL NOT affect the operation in progress.

Reset
REQ-029 When reset=1 at a clock edge, the following SHALL apply: state=IDLE, result=0, busy=0, done=0, counter=0, internal registers=0.
REQ-030 reset SHALL take priority over op_clear and op_start.
REQ-031 reset during CALC SHALL abort the operation, and no done pulse SHALL follow.

Structure
REQ-032 Package booth_pkg SHALL hold the FSM state typedef, the Booth digit encoding typedef (ZERO, POS1, NEG1, POS2, NEG2), and a function returning N for (WIDTH, RADIX4).
REQ-033 One combinational sub-module, booth_step, SHALL perform the recoding, add/subtract via a WIDTH-parametrised carry-lookahead adder, and the shift. It SHALL be parametrised by WIDTH and RADIX4.
REQ-034 booth_mult_seq SHALL contain only the FSM, the counter and the registers.

Verification (WIDTH=64)
REQ-035 Signed mode: A=-1, B=-1 -> result=0x1 with done=1. Radix-2: exactly 65 busy cycles. Radix-4: exactly 33 busy cycles.
REQ-036 Unsigned mode: A=B=0xFFFFFFFFFFFFFFFF -> result=0xFFFFFFFFFFFFFFFE_0000000000000001.
REQ-037 Signed mode: A=B=0x8000000000000000 -> result=0x4000000000000000_0000000000000000; A=0x8000000000000000, B=1 -> result=0xFFFFFFFFFFFFFFFF_8000000000000000.
REQ-038 Unsigned mode: A=0x21C3677C82B40000 (20!), B=21 -> result=0x2_C5077D36B8C40000 (21!), in both radix modes.
REQ-039 op_start with new operands at busy cycle 10 -> ignored; the original product completes on schedule.
REQ-040 op_clear at busy cycle 20 -> next cycle IDLE, result=0, no done. reset in DONE -> all outputs 0. op_clear+op_start in the same cycle -> IDLE.
